// File: rtl/inv_pkg.sv
// Shared constants for the registered inverting 4:1 mux.
package inv_pkg;

    // Select encodings, sel = {b0, a0}
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Default data width of each input and of f
    localparam int INV_WIDTH_DEF = 1;

endpackage

// File: rtl/inv_mux4.sv
// Purely combinational 4:1 selector. An unknown select falls back to input a
// so the case is always fully assigned and never infers a latch.
module inv_mux4
    import inv_pkg::*;
#(
    parameter int WIDTH = INV_WIDTH_DEF
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_y
);

    // Route the selected input to the output
    always_comb begin
        o_y = i_a;
        case (i_sel)
            SEL_A:   o_y = i_a;
            SEL_B:   o_y = i_b;
            SEL_C:   o_y = i_c;
            SEL_D:   o_y = i_d;
            default: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/inv.sv
// Registered, optionally inverting 4:1 multiplexer. One cycle of latency,
// one new input accepted every cycle; f is the only state in the block.
module inv
    import inv_pkg::*;
#(
    parameter int               WIDTH   = INV_WIDTH_DEF,
    parameter bit               INVERT  = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             a0,
    input  logic             b0,
    output logic [WIDTH-1:0] f
);

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_f;

    assign w_sel = {b0, a0};

    inv_mux4 #(
        .WIDTH(WIDTH)
    ) u_mux4 (
        .i_sel(w_sel),
        .i_a  (a),
        .i_b  (b),
        .i_c  (c),
        .i_d  (d),
        .o_y  (w_m)
    );

    // Build-time choice between complemented and pass-through data
    always_comb begin
        w_y = w_m;
        if (INVERT) begin
            w_y = ~w_m;
        end
    end

    // Output register; reset takes effect immediately and drops any pending value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= RST_VAL;
        end else begin
            r_f <= w_y;
        end
    end

    assign f = r_f;

endmodule

// File: tb/tb_inv.sv
// Self-checking bench for inv: a narrow inverting build (WIDTH=1, INVERT=1)
// and a wide pass-through build (WIDTH=4, INVERT=0) driven with the same data.
module tb_inv;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sa, sb, sc, sd;
    logic         sel_a0, sel_b0;
    logic [0:0]   f_n;
    logic [W-1:0] f_w;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_wide_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    inv #(
        .WIDTH  (1),
        .INVERT (1'b1),
        .RST_VAL(1'b0)
    ) dut_n (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (sa[0:0]),
        .b    (sb[0:0]),
        .c    (sc[0:0]),
        .d    (sd[0:0]),
        .a0   (sel_a0),
        .b0   (sel_b0),
        .f    (f_n)
    );

    inv #(
        .WIDTH  (W),
        .INVERT (1'b0),
        .RST_VAL(4'h0)
    ) dut_w (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (sa),
        .b    (sb),
        .c    (sc),
        .d    (sd),
        .a0   (sel_a0),
        .b0   (sel_b0),
        .f    (f_w)
    );

    // Reference selector
    function automatic logic [W-1:0] pick(input logic [1:0] sel,
                                          input logic [W-1:0] pa, pb, pc, pd);
        if (sel == 2'b00)      return pa;
        else if (sel == 2'b01) return pb;
        else if (sel == 2'b10) return pc;
        else                   return pd;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver: apply inputs at the falling edge, queue the expected results,
    // then compare just after the next rising edge
    task automatic step(input string tag, input logic [W-1:0] ta, tb_v, tc, td,
                        input logic [1:0] sel);
        logic [W-1:0] m;
        logic [W-1:0] mn;
        @(negedge clk);
        sa = ta; sb = tb_v; sc = tc; sd = td;
        sel_a0 = sel[0];
        sel_b0 = sel[1];
        m  = pick(sel, ta, tb_v, tc, td);
        mn = ~m;
        exp_q.push_back({3'b000, mn[0]});
        exp_wide_q.push_back(m);
        @(posedge clk);
        #1;
        check({tag, "_n"}, {3'b000, f_n}, exp_q.pop_front());
        check({tag, "_w"}, f_w, exp_wide_q.pop_front());
    endtask

    initial begin
        sa = '0; sb = '0; sc = '0; sd = '0;
        sel_a0 = 1'b0; sel_b0 = 1'b0;
        rst_n = 1'b1;

        // Reset asserted before the first clock edge must clear f at once
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_n", {3'b000, f_n}, 4'h0);
        check("rst_async_w", f_w, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_n", {3'b000, f_n}, 4'h0);
            check("rst_hold_w", f_w, 4'h0);
        end

        // Release: first edge with rst_n=1 loads ~a
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release", 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);

        // Select sweep
        step("sweep00", 4'h0, 4'h1, 4'h0, 4'h1, 2'b00);
        step("sweep01", 4'h0, 4'h1, 4'h0, 4'h1, 2'b01);
        step("sweep10", 4'h0, 4'h1, 4'h0, 4'h1, 2'b10);
        step("sweep11", 4'h0, 4'h1, 4'h0, 4'h1, 2'b11);

        // Data toggle on c at fixed select; other inputs must not matter
        step("ctog0", 4'hF, 4'hF, 4'h0, 4'hF, 2'b10);
        step("ctog1", 4'h0, 4'h1, 4'h1, 4'h0, 2'b10);
        step("ctog2", 4'hF, 4'h0, 4'h0, 4'hF, 2'b10);

        // Async reset in the middle of a sweep
        step("mid00", 4'h0, 4'h1, 4'h0, 4'h1, 2'b00);
        step("mid01", 4'h0, 4'h1, 4'h0, 4'h1, 2'b01);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_n", {3'b000, f_n}, 4'h0);
        check("mid_rst_w", f_w, 4'h0);
        @(posedge clk);
        #1;
        check("mid_rst_hold_n", {3'b000, f_n}, 4'h0);
        check("mid_rst_hold_w", f_w, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("mid10", 4'h0, 4'h1, 4'h0, 4'h1, 2'b10);
        step("mid11", 4'h0, 4'h1, 4'h0, 4'h1, 2'b11);

        // Wide pass-through values
        step("wide11", 4'h3, 4'hA, 4'h5, 4'hF, 2'b11);
        step("wide01", 4'h3, 4'hA, 4'h5, 4'hF, 2'b01);
        step("wide00", 4'h3, 4'hA, 4'h5, 4'hF, 2'b00);
        step("wide10", 4'h3, 4'hA, 4'h5, 4'hF, 2'b10);

        // Randomised back-to-back traffic
        for (int i = 0; i < 100; i++) begin
            step("rand",
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
        end

        check("queue_empty", 4'(exp_q.size() + exp_wide_q.size()), 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv.md
Name: inv

Overview:
- Registered, inverting 4:1 multiplexer.
- Two select bits (a0, b0) pick one of four data inputs (a, b, c, d).
- The chosen value is inverted and registered onto f.
- Used as a small datapath/steering leaf cell in lab-level designs; also a reference block for mux and inverter verification.

Parameters:
- WIDTH, 1, bit width of each data input and of f.
- INVERT, 1, 1 = f is the bitwise complement of the selected input; 0 = f is the selected input unchanged.
- RST_VAL, 0, value loaded into f on reset (WIDTH bits, zero-extended).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  data input 0, selected when {b0,a0}=2'b00.
- b  input  WIDTH  data input 1, selected when {b0,a0}=2'b01.
- c  input  WIDTH  data input 2, selected when {b0,a0}=2'b10.
- d  input  WIDTH  data input 3, selected when {b0,a0}=2'b11.
- a0  input  1  select LSB.
- b0  input  1  select MSB.
- f  output  WIDTH  registered mux/inverter result.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low: asserting rst_n=0 forces f=RST_VAL immediately, independent of clk.
- Reset:
  - While rst_n=0, f holds RST_VAL.
  - Deassertion is sampled on the next rising clk edge; the first update occurs on the first rising edge with rst_n=1.
  - Reset asserted mid-operation discards the pending value; no partial update.
- Select: sel = {b0,a0}. 00->a, 01->b, 10->c, 11->d.
- Combinational stage: m = selected input; y = INVERT ? ~m : m (bitwise over WIDTH).
- Register stage: on each rising clk with rst_n=1, f <= y.
- Latency: exactly 1 cycle from any input/select change to f.
- f changes only on a clock edge or on reset assertion; input glitches between edges are not visible on f.
- Simultaneous select and data change in the same cycle: f reflects the new select applied to the new data at the next edge.
- X/Z on select: the RTL uses a full case with a default branch returning a, so synthesis sees no latch. Simulation with a non-01 select is not required to be X-propagating.
- No handshake; the block accepts a new input every cycle (throughput 1/cycle).
- No internal state other than f.

Decomposition:
- Shared package (inv_pkg):
  - sel encoding constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - Default WIDTH constant.
- Sub-module mux4: purely combinational 4:1 selector, parameterized by WIDTH.
- inv instantiates mux4, applies the conditional inversion, and owns the output register and reset.

Test Plan:
- Reset:
  - Drive rst_n=0 with all inputs 0, clk running -> f=0 (RST_VAL) immediately and for all edges while low.
  - Release rst_n -> one edge later f=~a=1.
- Select sweep (WIDTH=1, INVERT=1):
  - a=0,b=1,c=0,d=1; step {b0,a0} through 00,01,10,11 one per cycle -> f = 1,0,1,0, each one cycle after its select.
- Data toggle at fixed select: {b0,a0}=10; toggle c 0->1->0 on consecutive cycles with a,b,d=1 -> f = 1,0,1 with 1-cycle lag; a,b,d changes have no effect on f.
- Async reset mid-stream: during the select sweep, assert rst_n=0 between clock edges -> f drops to 0 without waiting for clk; after release, the sweep resumes with 1-cycle latency.
- Non-inverting, wide build (WIDTH=4, INVERT=0): a=4'h3, b=4'hA, c=4'h5, d=4'hF, sel=11 -> f=4'hF next edge; sel=01 -> f=4'hA.
- Randomised free-running check: aa/bb/cc/dd/a0/b0 toggling at periods 10/20/30/40/50/60 ns for 1000 ns -> compare f every edge against a 1-cycle-delayed model ~mux(sel); zero mismatches.
